// File: rtl/uitpg_param_if.sv
// Video timing in / pattern out bundle for uitpg_param.
// The slave modport is the generator; the master modport is the timing source and sink.
interface uitpg_param_if #(
   parameter int CW = 8
);
   logic            I_tpg_vs;
   logic            I_tpg_hs;
   logic            I_tpg_de;
   logic [3:0]      I_dis_mode;
   logic            I_scroll_en;
   logic            O_tpg_vs;
   logic            O_tpg_hs;
   logic            O_tpg_de;
   logic [3*CW-1:0] O_tpg_data;
   logic [15:0]     O_frame_cnt;

   modport slave (
      input  I_tpg_vs, I_tpg_hs, I_tpg_de, I_dis_mode, I_scroll_en,
      output O_tpg_vs, O_tpg_hs, O_tpg_de, O_tpg_data, O_frame_cnt
   );

   modport master (
      output I_tpg_vs, I_tpg_hs, I_tpg_de, I_dis_mode, I_scroll_en,
      input  O_tpg_vs, O_tpg_hs, O_tpg_de, O_tpg_data, O_frame_cnt
   );
endinterface

// File: rtl/uitpg_param.sv
// Parametrised RGB test pattern generator with a fixed 2-cycle pipeline from VS/HS/DE.
// Optional border overlay: define TPG_BORDER_EN.
module uitpg_param #(
   parameter int CW          = 8,
   parameter int H_ACTIVE    = 1920,
   parameter int V_ACTIVE    = 1080,
   parameter int GRID_LOG2   = 4,
   parameter int BAR_NUM     = 8,
   parameter int SCROLL_STEP = 1
) (
   input  logic         I_tpg_clk,
   input  logic         I_tpg_rst,
   uitpg_param_if.slave tpg
);
   localparam int          BW_RAW   = H_ACTIVE / BAR_NUM;
   localparam int          BW       = (BW_RAW < 1) ? 1 : BW_RAW;
   localparam logic [11:0] BW_M1    = 12'(BW - 1);
   localparam logic [3:0]  BAR_LAST = 4'(BAR_NUM - 1);
   localparam logic [11:0] STEP     = 12'(SCROLL_STEP);
   localparam logic [CW-1:0] ONES   = {CW{1'b1}};
   localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

   logic [11:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [11:0]     offset_q, offset_d, bar_pix_q, bar_pix_d;
   logic [3:0]      bar_idx_q, bar_idx_d, mode_q, mode_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            vs_p1_q, hs_p1_q, de_p1_q;
   logic            vs_o_q, hs_o_q, de_o_q;
   logic [3*CW-1:0] pix_d, pix_p1_q, data_o_q;
   logic            vs_rise, de_fall, grid, hatch;
   logic [11:0]     x, xy;
   logic [CW-1:0]   x_ramp, y_ramp, xy_ramp;
   logic [2:0]      bar_rgb;

   // Stage-1 sync registers double as the previous-cycle values for edge detection.
   assign vs_rise = tpg.I_tpg_vs & ~vs_p1_q;
   assign de_fall = de_p1_q & ~tpg.I_tpg_de;
   assign x       = h_cnt_q + offset_q;
   assign xy      = x + v_cnt_q;
   assign grid    = x[GRID_LOG2] ^ v_cnt_q[GRID_LOG2];
   assign hatch   = (x[GRID_LOG2-1:0] == '0) || (v_cnt_q[GRID_LOG2-1:0] == '0);

   generate
      if (CW > 12) begin : g_ramp_ext
         assign x_ramp  = {{(CW-12){1'b0}}, x};
         assign y_ramp  = {{(CW-12){1'b0}}, v_cnt_q};
         assign xy_ramp = {{(CW-12){1'b0}}, xy};
      end else begin : g_ramp_trunc
         assign x_ramp  = x[CW-1:0];
         assign y_ramp  = v_cnt_q[CW-1:0];
         assign xy_ramp = xy[CW-1:0];
      end
   endgenerate

   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      offset_d    = offset_q;
      bar_pix_d   = bar_pix_q;
      bar_idx_d   = bar_idx_q;
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      if (vs_rise) begin
         h_cnt_d     = '0;
         v_cnt_d     = '0;
         bar_pix_d   = '0;
         bar_idx_d   = '0;
         frame_cnt_d = frame_cnt_q + 16'd1;
         mode_d      = tpg.I_dis_mode;
         offset_d    = tpg.I_scroll_en ? offset_q + STEP : 12'd0;
      end else begin
         h_cnt_d = tpg.I_tpg_de ? h_cnt_q + 12'd1 : 12'd0;
         if (de_fall) v_cnt_d = v_cnt_q + 12'd1;
         if (!tpg.I_tpg_de) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
         end else if (bar_idx_q != BAR_LAST) begin
            if (bar_pix_q == BW_M1) begin
               bar_pix_d = '0;
               bar_idx_d = bar_idx_q + 4'd1;
            end else begin
               bar_pix_d = bar_pix_q + 12'd1;
            end
         end
      end
   end

   always_comb begin
      bar_rgb = 3'b000;
      case (bar_idx_q[2:0])
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase
   end

   always_comb begin
      pix_d = '0;
      case (mode_q)
         4'd1:    pix_d = {ONES, ONES, ONES};
         4'd2:    pix_d = {ONES, ZERO, ZERO};
         4'd3:    pix_d = {ZERO, ONES, ZERO};
         4'd4:    pix_d = {ZERO, ZERO, ONES};
         4'd5:    pix_d = grid ? '0 : {ONES, ONES, ONES};
         4'd6:    pix_d = {x_ramp, x_ramp, x_ramp};
         4'd7:    pix_d = {y_ramp, y_ramp, y_ramp};
         4'd8:    pix_d = {x_ramp, ZERO, ZERO};
         4'd9:    pix_d = {ZERO, x_ramp, ZERO};
         4'd10:   pix_d = {ZERO, ZERO, x_ramp};
         4'd11:   pix_d = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
         4'd12:   pix_d = {xy_ramp, xy_ramp, xy_ramp};
         4'd13:   pix_d = (grid ^ frame_cnt_q[0]) ? '0 : {ONES, ONES, ONES};
         4'd14:   pix_d = hatch ? {ONES, ONES, ONES} : '0;
         default: pix_d = '0;
      endcase
`ifdef TPG_BORDER_EN
      if (h_cnt_q == 12'd0 || h_cnt_q == 12'(H_ACTIVE - 1) ||
          v_cnt_q == 12'd0 || v_cnt_q == 12'(V_ACTIVE - 1))
         pix_d = '1;
`endif
   end

   always_ff @(posedge I_tpg_clk) begin
      if (I_tpg_rst) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         offset_q    <= '0;
         bar_pix_q   <= '0;
         bar_idx_q   <= '0;
         mode_q      <= '0;
         frame_cnt_q <= '0;
         vs_p1_q     <= 1'b0;
         hs_p1_q     <= 1'b0;
         de_p1_q     <= 1'b0;
         pix_p1_q    <= '0;
         vs_o_q      <= 1'b0;
         hs_o_q      <= 1'b0;
         de_o_q      <= 1'b0;
         data_o_q    <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         offset_q    <= offset_d;
         bar_pix_q   <= bar_pix_d;
         bar_idx_q   <= bar_idx_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         vs_p1_q     <= tpg.I_tpg_vs;
         hs_p1_q     <= tpg.I_tpg_hs;
         de_p1_q     <= tpg.I_tpg_de;
         pix_p1_q    <= pix_d;
         vs_o_q      <= vs_p1_q;
         hs_o_q      <= hs_p1_q;
         de_o_q      <= de_p1_q;
         data_o_q    <= de_p1_q ? pix_p1_q : '0;
      end
   end

   assign tpg.O_tpg_vs    = vs_o_q;
   assign tpg.O_tpg_hs    = hs_o_q;
   assign tpg.O_tpg_de    = de_o_q;
   assign tpg.O_tpg_data  = data_o_q;
   assign tpg.O_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_uitpg_param.sv
// Directed bench for uitpg_param: vector table of per-mode pixel probes plus
// hand sequences for frame-sync mode switching, scroll, checker parity and mid-frame reset.
module tb_uitpg_param;
   localparam int CW = 8;
   localparam int HA = 100;
   localparam int VA = 8;
   localparam int GL = 3;
   localparam int BN = 8;
   localparam int ST = 4;

   logic clk = 1'b0;
   logic rst;
   uitpg_param_if #(.CW(CW)) bus ();

   uitpg_param #(
      .CW(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .GRID_LOG2(GL), .BAR_NUM(BN), .SCROLL_STEP(ST)
   ) dut (
      .I_tpg_clk (clk),
      .I_tpg_rst (rst),
      .tpg       (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int fc = 0;
   bit chk_pipe = 1'b0;

   logic [23:0] cap [0:7][0:299];
   int          cap_line = 0;
   int          cap_pix = 0;
   logic        ovs_prev = 1'b0;
   logic        ode_prev = 1'b0;
   logic [2:0]  in_h1 = 3'b000;
   logic [2:0]  in_h2 = 3'b000;

   typedef struct {
      logic [3:0]  mode;
      bit          run;
      int          nl;
      int          ppl;
      int          line;
      int          pix;
      logic [23:0] exp;
   } vec_t;
   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] grid_px(input int xv, input int yv);
      logic [11:0] xb, yb;
      xb = 12'(xv);
      yb = 12'(yv);
      return (xb[GL] ^ yb[GL]) ? 24'h000000 : 24'hFFFFFF;
   endfunction

   // Output monitor: captures active pixels and checks the 2-cycle sync alignment.
   always @(negedge clk) begin
      if (bus.O_tpg_vs && !ovs_prev) begin
         cap_line <= 0;
         cap_pix  <= 0;
      end else if (bus.O_tpg_de) begin
         if (cap_line < 8 && cap_pix < 300) cap[cap_line][cap_pix] <= bus.O_tpg_data;
         cap_pix <= cap_pix + 1;
      end else if (ode_prev) begin
         cap_line <= cap_line + 1;
         cap_pix  <= 0;
      end
      if (chk_pipe) begin
         check("sync_pipe", {29'd0, bus.O_tpg_vs, bus.O_tpg_hs, bus.O_tpg_de}, {29'd0, in_h2});
         if (!bus.O_tpg_de) check("data_zero_no_de", {8'd0, bus.O_tpg_data}, 32'd0);
      end
      in_h1    <= {bus.I_tpg_vs, bus.I_tpg_hs, bus.I_tpg_de};
      in_h2    <= in_h1;
      ovs_prev <= bus.O_tpg_vs;
      ode_prev <= bus.O_tpg_de;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic run_frame(input logic [3:0] mode, input logic scr, input int nl, input int ppl,
                            input int chg_line, input logic [3:0] chg_mode);
      bus.I_dis_mode  = mode;
      bus.I_scroll_en = scr;
      bus.I_tpg_vs = 1'b1; idle(2);
      bus.I_tpg_vs = 1'b0; idle(2);
      for (int l = 0; l < nl; l++) begin
         if (l == chg_line) bus.I_dis_mode = chg_mode;
         bus.I_tpg_hs = 1'b1; idle(2);
         bus.I_tpg_hs = 1'b0; idle(2);
         bus.I_tpg_de = 1'b1; idle(ppl);
         bus.I_tpg_de = 1'b0; idle(3);
      end
      idle(4);
      fc++;
      $display("frame %0d mode=%0d scroll=%0d lines=%0d ppl=%0d", fc, mode, scr, nl, ppl);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] f0 [0:39];
      logic [23:0] expv;
      int errs;

      tv.push_back('{4'd6,  1'b1, 2, 300, 0, 0,   24'h000000});
      tv.push_back('{4'd6,  1'b0, 2, 300, 0, 5,   24'h050505});
      tv.push_back('{4'd6,  1'b0, 2, 300, 0, 255, 24'hFFFFFF});
      tv.push_back('{4'd6,  1'b0, 2, 300, 0, 256, 24'h000000});
      tv.push_back('{4'd6,  1'b0, 2, 300, 1, 299, 24'h2B2B2B});
      tv.push_back('{4'd7,  1'b1, 4, 8,   0, 3,   24'h000000});
      tv.push_back('{4'd7,  1'b0, 4, 8,   2, 0,   24'h020202});
      tv.push_back('{4'd7,  1'b0, 4, 8,   3, 7,   24'h030303});
      tv.push_back('{4'd11, 1'b1, 1, 100, 0, 0,   24'hFFFFFF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 11,  24'hFFFFFF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 12,  24'hFFFF00});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 23,  24'hFFFF00});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 24,  24'h00FFFF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 36,  24'h00FF00});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 48,  24'hFF00FF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 60,  24'hFF0000});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 72,  24'h0000FF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 83,  24'h0000FF});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 84,  24'h000000});
      tv.push_back('{4'd11, 1'b0, 1, 100, 0, 99,  24'h000000});
      tv.push_back('{4'd8,  1'b1, 1, 20,  0, 10,  24'h0A0000});
      tv.push_back('{4'd9,  1'b1, 1, 20,  0, 10,  24'h000A00});
      tv.push_back('{4'd10, 1'b1, 1, 20,  0, 17,  24'h000011});
      tv.push_back('{4'd3,  1'b1, 1, 8,   0, 0,   24'h00FF00});
      tv.push_back('{4'd4,  1'b1, 1, 8,   0, 5,   24'h0000FF});
      tv.push_back('{4'd0,  1'b1, 1, 8,   0, 5,   24'h000000});
      tv.push_back('{4'd15, 1'b1, 1, 8,   0, 5,   24'h000000});
      tv.push_back('{4'd12, 1'b1, 3, 8,   2, 5,   24'h070707});
      tv.push_back('{4'd12, 1'b0, 3, 8,   1, 0,   24'h010101});
      tv.push_back('{4'd5,  1'b1, 2, 24,  0, 7,   24'hFFFFFF});
      tv.push_back('{4'd5,  1'b0, 2, 24,  0, 8,   24'h000000});
      tv.push_back('{4'd5,  1'b0, 2, 24,  0, 16,  24'hFFFFFF});
      tv.push_back('{4'd5,  1'b0, 2, 24,  1, 8,   24'h000000});
      tv.push_back('{4'd14, 1'b1, 2, 16,  0, 5,   24'hFFFFFF});
      tv.push_back('{4'd14, 1'b0, 2, 16,  1, 0,   24'hFFFFFF});
      tv.push_back('{4'd14, 1'b0, 2, 16,  1, 1,   24'h000000});
      tv.push_back('{4'd14, 1'b0, 2, 16,  1, 8,   24'hFFFFFF});
      tv.push_back('{4'd14, 1'b0, 2, 16,  1, 9,   24'h000000});
      tv.push_back('{4'd2,  1'b1, 1, 8,   0, 7,   24'hFF0000});

      rst = 1'b1;
      bus.I_tpg_vs = 1'b0; bus.I_tpg_hs = 1'b0; bus.I_tpg_de = 1'b0;
      bus.I_dis_mode = 4'd0; bus.I_scroll_en = 1'b0;
      idle(3);
      @(negedge clk);
      check("rst_data", {8'd0, bus.O_tpg_data}, 32'd0);
      check("rst_sync", {29'd0, bus.O_tpg_vs, bus.O_tpg_hs, bus.O_tpg_de}, 32'd0);
      check("rst_frame_cnt", {16'd0, bus.O_frame_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      chk_pipe = 1'b1;
      $display("reset done");

      // Two white frames of 64x8.
      for (int f = 0; f < 2; f++) begin
         run_frame(4'd1, 1'b0, 8, 64, -1, 4'd0);
         check("m1_lines", cap_line, 8);
         for (int l = 0; l < 8; l++)
            for (int p = 0; p < 64; p++)
               check($sformatf("m1_white_l%0d_p%0d", l, p), {8'd0, cap[l][p]}, 32'hFFFFFF);
      end
      check("frame_cnt_2", {16'd0, bus.O_frame_cnt}, 32'd2);

      // Mode request changes mid-frame: only takes effect at the next VS rise.
      run_frame(4'd1, 1'b0, 4, 16, 2, 4'd2);
      for (int l = 0; l < 4; l++)
         for (int p = 0; p < 16; p++)
            check($sformatf("midchg_white_l%0d_p%0d", l, p), {8'd0, cap[l][p]}, 32'hFFFFFF);
      run_frame(4'd2, 1'b0, 4, 16, -1, 4'd0);
      for (int l = 0; l < 4; l++)
         for (int p = 0; p < 16; p++)
            check($sformatf("midchg_red_l%0d_p%0d", l, p), {8'd0, cap[l][p]}, 32'hFF0000);

      foreach (tv[i]) begin
         if (tv[i].run) begin
            run_frame(tv[i].mode, 1'b0, tv[i].nl, tv[i].ppl, -1, 4'd0);
            check($sformatf("vec%0d_lines", i), cap_line, tv[i].nl);
         end
         check($sformatf("vec%0d_mode%0d_l%0d_p%0d", i, tv[i].mode, tv[i].line, tv[i].pix),
               {8'd0, cap[tv[i].line][tv[i].pix]}, {8'd0, tv[i].exp});
         $display("vec %0d mode=%0d line=%0d pix=%0d got=%06h exp=%06h", i, tv[i].mode,
                  tv[i].line, tv[i].pix, cap[tv[i].line][tv[i].pix], tv[i].exp);
      end

      // Checker inverts on odd frame count.
      for (int f = 0; f < 2; f++) begin
         run_frame(4'd13, 1'b0, 1, 16, -1, 4'd0);
         expv = (fc % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
         check($sformatf("checker_fc%0d_p0", fc), {8'd0, cap[0][0]}, {8'd0, expv});
         check($sformatf("checker_fc%0d_p8", fc), {8'd0, cap[0][8]}, {8'd0, ~expv});
      end

      // Scroll: frame k pixel p equals frame 0 pixel p+4k.
      for (int k = 0; k < 3; k++) begin
         run_frame(4'd5, 1'b1, 1, 40, -1, 4'd0);
         if (k == 0) begin
            for (int p = 0; p < 40; p++) f0[p] = cap[0][p];
         end else begin
            for (int p = 0; p < 40 - ST * k; p++)
               check($sformatf("scroll_k%0d_p%0d", k, p), {8'd0, cap[0][p]}, {8'd0, f0[p + ST * k]});
         end
      end
      errs = 0;
      for (int p = 0; p < 40; p++) if (f0[p] !== grid_px(p, 0)) errs++;
      check("scroll_moved", (errs != 0) ? 32'd1 : 32'd0, 32'd1);
      for (int k = 0; k < 2; k++) begin
         run_frame(4'd5, 1'b0, 1, 40, -1, 4'd0);
         for (int p = 0; p < 40; p++)
            check($sformatf("scroll_off_f%0d_p%0d", k, p), {8'd0, cap[0][p]}, {8'd0, grid_px(p, 0)});
      end

      // Border overlay (all zero without the overlay) on a mode-0 frame.
      run_frame(4'd0, 1'b0, 8, 100, -1, 4'd0);
      for (int l = 0; l < 8; l++)
         for (int p = 0; p < 100; p++) begin
`ifdef TPG_BORDER_EN
            expv = (p == 0 || p == HA - 1 || l == 0 || l == VA - 1) ? 24'hFFFFFF : 24'h000000;
`else
            expv = 24'h000000;
`endif
            check($sformatf("border_l%0d_p%0d", l, p), {8'd0, cap[l][p]}, {8'd0, expv});
         end

      // Reset asserted mid-line while white is streaming.
      bus.I_dis_mode = 4'd1;
      bus.I_tpg_vs = 1'b1; idle(2);
      bus.I_tpg_vs = 1'b0; idle(2);
      bus.I_tpg_de = 1'b1; idle(10);
      @(negedge clk);
      check("pre_rst_white", {8'd0, bus.O_tpg_data}, 32'hFFFFFF);
      chk_pipe = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_data", {8'd0, bus.O_tpg_data}, 32'd0);
      check("midrst_de", {31'd0, bus.O_tpg_de}, 32'd0);
      check("midrst_frame_cnt", {16'd0, bus.O_frame_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      fc = 0;
      $display("mid-frame reset applied");
      for (int c = 0; c < 12; c++) begin
         tick();
         @(negedge clk);
         check($sformatf("post_rst_mode0_c%0d", c), {8'd0, bus.O_tpg_data}, 32'd0);
         if (c == 4) check("post_rst_de", {31'd0, bus.O_tpg_de}, 32'd1);
      end
      bus.I_tpg_de = 1'b0;
      idle(4);
      chk_pipe = 1'b1;
      run_frame(4'd1, 1'b0, 1, 16, -1, 4'd0);
      for (int p = 0; p < 16; p++)
         check($sformatf("post_rst_white_p%0d", p), {8'd0, cap[0][p]}, 32'hFFFFFF);
      check("post_rst_frame_cnt", {16'd0, bus.O_frame_cnt}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uitpg_param.md
Name: uitpg_param

Overview:
Parametrised successor to the static test pattern generator. It takes upstream VS/HS/DE timing and produces a selectable RGB test pattern, with channel width and geometry set by parameters. It adds frame-synchronous mode switching, animated horizontal scroll, a frame counter and sync outputs pipeline-aligned to the data. It sits between the video timing generator and the display/HDMI encoder.

Parameters:
CW, 8, bits per colour channel (4..12); O_tpg_data is 3*CW wide.
H_ACTIVE, 1920, active pixels per line (≤4095).
V_ACTIVE, 1080, active lines per frame (≤4095).
GRID_LOG2, 4, log2 of grid/checker cell size in pixels.
BAR_NUM, 8, number of colour bars (1..16).
SCROLL_STEP, 1, pixels of horizontal shift per frame when scrolling.

Ports:
I_tpg_clk  in  1  pixel clock
I_tpg_rst  in  1  reset, synchronous, active-high
I_tpg_vs  in  1  vertical sync, active-high
I_tpg_hs  in  1  horizontal sync
I_tpg_de  in  1  active-video enable
I_dis_mode  in  4  pattern select, sampled once per frame
I_scroll_en  in  1  enable horizontal scroll, sampled once per frame
O_tpg_vs  out  1  VS delayed 2 cycles
O_tpg_hs  out  1  HS delayed 2 cycles
O_tpg_de  out  1  DE delayed 2 cycles
O_tpg_data  out  3*CW  {R,G,B} pixel data
O_frame_cnt  out  16  frames since reset

Behaviour:
- Reset: all outputs 0; h_cnt, v_cnt, frame_cnt, offset and active mode 0; scroll disabled; sync pipelines cleared.
- Latency: fixed 2 cycles. O_tpg_vs/hs/de are the inputs delayed 2 registers, and O_tpg_data belongs to the input pixel 2 cycles earlier.
- O_tpg_data is 0 whenever delayed DE is 0.
- h_cnt (12b): 0 on the first DE-high pixel, +1 per DE-high cycle, cleared while DE is low.
- v_cnt (12b): cleared on VS rising edge; +1 on DE falling edge, so line 0 is the first active line. It does not depend on HS polarity.
- Frame event on VS rising edge:
  - frame_cnt +1, wrapping at 16 bits.
  - Active mode loads from I_dis_mode and scroll flag from I_scroll_en; mid-frame changes have no effect until the next VS rise.
  - offset becomes offset+SCROLL_STEP mod 4096 if scroll is on, else 0.
- Coordinates: x = (h_cnt + offset) mod 4096; y = v_cnt. Ramps use the low CW bits, zero-extended when CW > 12.
- Modes:
  - 0 black; 1 white; 2 red; 3 green; 4 blue.
  - 5 grid: black where x[GRID_LOG2]^y[GRID_LOG2], else white.
  - 6 horizontal grey ramp of x; 7 vertical grey ramp of y.
  - 8/9/10 horizontal ramp on R/G/B only.
  - 11 colour bars: bar width BW = H_ACTIVE/BAR_NUM (integer). Bars use unscrolled h_cnt, tracked by a bar-pixel counter (no divider). The bar index saturates at BAR_NUM-1 for leftover pixels. Colour order by index mod 8: white, yellow, cyan, green, magenta, red, blue, black.
  - 12 diagonal grey ramp of (x+y).
  - 13 checker as mode 5, inverted when frame_cnt[0]=1.
  - 14 crosshatch: white where x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else black.
  - 15 black (reserved).
- Simultaneous VS rise and DE high: the frame event takes priority and counters are cleared. Inputs are otherwise undefined in that case.
- Reset asserted mid-frame: outputs are 0 on the next cycle. Patterns resume on DE after reset, with mode 0 until the next VS rise.

Optional Feature:
TPG_BORDER_EN:
- Defined: pixels with unscrolled h_cnt==0, h_cnt==H_ACTIVE-1, v_cnt==0 or v_cnt==V_ACTIVE-1 are forced to all-ones in every mode, with the same 2-cycle latency.
- Undefined: no override and no border comparators synthesised.

Test Plan:
- Reset 3 cycles, then 2 frames of 64x8 timing with mode 1 → O_tpg_data=24'hFFFFFF exactly where O_tpg_de=1; delayed DE equals input DE shifted 2 cycles; O_frame_cnt=2.
- Mode changes 1→2 mid-frame → remainder of frame stays white; from the next VS rise, data=24'hFF0000.
- Mode 6, CW=8, H_ACTIVE=300 → pixel n carries n mod 256; pixel 256 = 8'h00.
- Mode 11, H_ACTIVE=100, BAR_NUM=8 → BW=12; pixels 0–11 white, 12–23 yellow, 84–99 black (index saturated at 7).
- Mode 5, I_scroll_en=1, SCROLL_STEP=4 → frame k pixel 0 equals frame 0 pixel 4k; scroll off resets the offset to 0 at the next frame.
- With TPG_BORDER_EN defined, mode 0, 64x8 timing → first/last pixel of each line and all of lines 0 and 7 are all-ones; the interior is 0.
